// File: rtl/toggle_event_receiver.sv
// ============================================================================
// Module  : toggle_event_receiver
// Purpose : Destination side of a toggle-signalling CDC path. It emits an event
//           pulse, a coalesced event count on valid/ready, and an optional ack.
// Options : define TOGGLE_EVENT_RX_ACK_EN to build the acknowledge toggle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             toggle_i,
  output logic             evt_pulse_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [CNT_W-1:0] evt_count_o,
  output logic             overflow_o,
  output logic             ack_toggle_o
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int               ARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   toggle_q;
  state_t                 state_q;
  logic [ARM_W-1:0]       arm_cnt_q;
  logic [CNT_W-1:0]       pend_q;
  logic                   pulse_q;
  logic                   valid_q;
  logic                   ovf_q;

  logic                   sync_s;
  logic                   flip;
  logic                   hs;
  logic                   at_max;
  logic [CNT_W-1:0]       pend_inc_d;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  // Edges are ignored while arming so a chain still settling after reset never counts.
  assign flip       = (sync_s ^ toggle_q) && (state_q != ST_ARM);
  assign hs         = valid_q & evt_ready_i;
  assign at_max     = (pend_q == CNT_MAX);
  assign pend_inc_d = pend_q + CNT_ONE;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q   <= '0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      toggle_q <= sync_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_ARM;
      arm_cnt_q <= '0;
      pend_q    <= '0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pulse_q <= flip;
      case (state_q)
        ST_ARM: begin
          valid_q <= 1'b0;
          pend_q  <= '0;
          if (arm_cnt_q == ARM_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        ST_IDLE: begin
          valid_q <= 1'b0;
          pend_q  <= '0;
          if (flip) begin
            pend_q  <= CNT_ONE;
            valid_q <= 1'b1;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (hs && flip) begin
            // The consumer takes the old count; the new edge starts a fresh one.
            pend_q <= CNT_ONE;
          end else if (hs) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (flip) begin
            if (at_max) begin
              ovf_q <= 1'b1;
            end else begin
              pend_q <= pend_inc_d;
            end
          end
        end
        default: begin
          state_q <= ST_ARM;
          valid_q <= 1'b0;
          pend_q  <= '0;
        end
      endcase
    end
  end

  assign evt_pulse_o = pulse_q;
  assign evt_valid_o = valid_q;
  assign evt_count_o = pend_q;
  assign overflow_o  = ovf_q;

`ifdef TOGGLE_EVENT_RX_ACK_EN
  logic ack_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ack_q <= 1'b0;
    end else if (hs) begin
      ack_q <= ~ack_q;
    end
  end

  assign ack_toggle_o = ack_q;
`else
  assign ack_toggle_o = 1'b0;
`endif

endmodule

`default_nettype wire
